// File: rtl/ex_stage_bju.sv
// ex_stage_bju: EX branch/jump resolution with registered IF redirect and IF/ID flush; BJU_PERF_CNT_EN adds branch/taken counters.
module ex_stage_bju #(
  parameter int XLEN = 64,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_ex_valid,
  output logic            o_ex_ready,
  input  logic [XLEN-1:0] i_ex_pc,
  input  logic [7:0]      i_bj_info,
  input  logic [7:0]      i_bj_data,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_imm,
  output logic [XLEN-1:0] o_link_data,
  output logic            o_redirect_valid,
  input  logic            i_redirect_ready,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_flush_if_id,
  output logic            o_misalign_exc,
  output logic [XLEN-1:0] o_misalign_tval
`ifdef BJU_PERF_CNT_EN
  ,
  output logic [63:0]     o_perf_branch_cnt,
  output logic [63:0]     o_perf_taken_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
  state_t r_state, w_next;
  logic [2:0] r_cnt, w_cnt_next;
  logic w_accept, w_taken, w_misalign;
  logic [XLEN-1:0] w_jalr_sum, w_target;
  assign o_ex_ready  = r_state == IDLE;
  assign w_accept    = i_ex_valid & o_ex_ready;
  assign w_taken     = |(i_bj_info & i_bj_data);
  assign w_jalr_sum  = i_rs1_data + i_imm;
  assign w_target    = i_bj_info[6] ? {w_jalr_sum[XLEN-1:1], 1'b0} : i_ex_pc + i_imm;
  assign w_misalign  = w_target[1];
  assign o_link_data = i_ex_pc + XLEN'(4);
  always_comb begin
    w_next = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      IDLE: w_next = (w_accept & w_taken & ~w_misalign) ? REQ : IDLE;
      REQ: begin
        w_next = i_redirect_ready ? DRAIN : REQ;
        w_cnt_next = i_redirect_ready ? 3'(DRAIN_CYCLES) : r_cnt;
      end
      DRAIN: begin
        w_next = (r_cnt == 3'd1) ? IDLE : DRAIN;
        w_cnt_next = r_cnt - 3'd1;
      end
      default: w_next = IDLE;
    endcase
  end
  // Status outputs are flopped from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      o_redirect_valid <= 1'b0;
      o_redirect_pc <= '0;
      o_flush_if_id <= 1'b0;
      o_misalign_exc <= 1'b0;
      o_misalign_tval <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_cnt_next;
      o_redirect_valid <= w_next == REQ;
      o_flush_if_id <= w_next != IDLE;
      o_misalign_exc <= w_accept & w_taken & w_misalign;
      if (w_accept & w_taken & w_misalign) o_misalign_tval <= w_target;
      if (r_state == IDLE && w_next == REQ) o_redirect_pc <= w_target;
    end
  end
`ifdef BJU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_perf_branch_cnt <= '0;
      o_perf_taken_cnt <= '0;
    end else begin
      if (w_accept & |i_bj_info) o_perf_branch_cnt <= o_perf_branch_cnt + 64'd1;
      if (w_accept & w_taken) o_perf_taken_cnt <= o_perf_taken_cnt + 64'd1;
    end
  end
`endif
endmodule

// File: doc/ex_stage_bju.md
Name: ex_stage_bju

Overview:
- Branch/jump resolution unit in EX. It consumes the ALU's per-condition compare vector (bj_data) and the decoder's one-hot branch type.
- It computes the taken decision and target. It issues a registered PC redirect to IF over a valid/ready handshake and flushes IF/ID while the redirect is outstanding.
- Static not-taken front end: every taken branch or jump redirects.

Parameters:
- XLEN, 64, datapath width.
- DRAIN_CYCLES, 2, cycles flush_if_id stays high after the redirect handshake completes (range 1..7).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  EX holds a valid instruction
- ex_ready  out  1  unit can accept an instruction this cycle
- ex_pc  in  XLEN  PC of the EX instruction
- bj_info  in  8  one-hot type; bit order BEQ,BNE,BLT,BGE,BLTU,BGEU,JALR,JAL (bit0..bit7); all-zero means not a branch
- bj_data  in  8  ALU condition vector, same bit order
- rs1_data  in  XLEN  JALR base
- imm  in  XLEN  sign-extended offset
- link_data  out  XLEN  ex_pc+4, for the JAL/JALR rd writeback
- redirect_valid  out  1  redirect request to IF
- redirect_ready  in  1  IF accepts redirect
- redirect_pc  out  XLEN  new fetch PC
- flush_if_id  out  1  kill younger instructions in IF and ID
- misalign_exc  out  1  one-cycle pulse: taken target not 4-byte aligned
- misalign_tval  out  XLEN  faulting target, held until next exception

Behaviour:
- Reset (synchronous, active-high rst): state=IDLE. redirect_valid=0, redirect_pc=0, flush_if_id=0, misalign_exc=0, misalign_tval=0, drain counter=0. A reset in any state drops an outstanding redirect immediately, with no handshake.
- Decision:
  - taken = |(bj_info & bj_data).
  - JAL and JALR: bj_data bits are 1 by construction, so they are always taken.
- Target:
  - JALR: (rs1_data+imm) with bit0 cleared.
  - Others: ex_pc+imm.
  - All sums are modulo 2^XLEN; wrap-around is silently ignored.
- link_data = ex_pc+4, combinational, modulo 2^XLEN.
- ex_ready = (state==IDLE). The instruction is accepted on ex_valid & ex_ready.
- FSM:
  - IDLE:
    - Accept with taken and target[1]==0: capture redirect_pc, go to REQ.
    - Accept with taken and target[1]==1: next cycle misalign_exc=1 for exactly one cycle, misalign_tval=target; stay IDLE with no redirect.
    - Accept with not taken, or bj_info==0: stay IDLE.
  - REQ:
    - redirect_valid=1 and flush_if_id=1.
    - redirect_pc stays stable until the handshake.
    - On redirect_valid & redirect_ready: load the drain counter with DRAIN_CYCLES and go to DRAIN.
    - Otherwise hold indefinitely.
  - DRAIN:
    - redirect_valid=0, flush_if_id=1.
    - Counter decrements each cycle; at 1, go to IDLE.
- Latency: accept at cycle N gives redirect_valid at N+1. With redirect_ready=1 at N+1, flush_if_id is high for cycles N+1..N+1+DRAIN_CYCLES and ex_ready returns at N+2+DRAIN_CYCLES.
- Simultaneous events:
  - ex_valid while not IDLE is ignored (ex_ready=0; upstream must hold).
  - redirect_ready when not in REQ is ignored.
- bj_info not one-hot (more than one bit set) is undefined. Verification constrains it to be one-hot or zero.
- All outputs except link_data and ex_ready are registered.

Optional Feature:
- Macro: BJU_PERF_CNT_EN.
- With the macro defined:
  - Output ports perf_branch_cnt [63:0] and perf_taken_cnt [63:0] are added.
  - perf_branch_cnt increments on each accepted instruction with bj_info!=0.
  - perf_taken_cnt increments on each accepted taken instruction, misaligned ones included.
  - Both counters reset to 0 on rst and wrap at 2^64.
- Without the macro: the ports and counters do not exist, and there is no other behavioural change.

Test Plan:
- BEQ, ex_pc=0x8000_0100, imm=0x40, bj_data[0]=1, redirect_ready=1 -> redirect_valid at N+1 with redirect_pc=0x8000_0140; flush_if_id high for 3 cycles (DRAIN_CYCLES=2); ex_ready low for 3 cycles.
- BNE with bj_data[1]=0 -> no redirect, flush_if_id=0, ex_ready stays 1; perf_taken_cnt unchanged and perf_branch_cnt +1 when BJU_PERF_CNT_EN is defined.
- JALR, rs1_data=0x8000_0013, imm=0x5 -> target 0x8000_0018; redirect_pc=0x8000_0018; link_data=ex_pc+4.
- JAL, ex_pc=0x1000, imm=0x2 -> misalign_exc pulses 1 cycle with misalign_tval=0x1002; no redirect_valid.
- Taken BLT with redirect_ready held 0 for 5 cycles -> redirect_valid and redirect_pc stable for 5 cycles; a new ex_valid is not accepted; handshake on cycle 6, then DRAIN.
- rst asserted while in REQ -> next cycle redirect_valid=0, flush_if_id=0, ex_ready=1, and the counters are 0 when BJU_PERF_CNT_EN is defined.
